// File: rtl/sp1_arb4.sv
// Four-requester round-robin arbiter with grant held until the owner signals done.
// Optional watchdog (macro SP1_ARB_TIMEOUT_EN) forces a release after TMO cycles without done.
module sp1_arb4 #(
  parameter int unsigned TMO = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       tmo
);

  typedef enum logic {S_IDLE = 1'b0, S_OWN = 1'b1} state_t;

  if (TMO < 1 || TMO > 255) begin : g_bad_tmo
    $error("sp1_arb4: TMO must be in 1..255");
  end

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] gnt_id_q, gnt_id_d;
  logic       busy_q, busy_d;
  logic       tmo_q, tmo_d;
  logic [1:0] ptr_q, ptr_d;

  logic       tmo_fire;
  logic       release_w;
  logic [1:0] rel_ptr;
  logic [3:0] masked_req;
  logic [2:0] sel_idle;
  logic [2:0] sel_own;

  // Returns {found, index} of the first set bit at or after p, ascending modulo 4.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [2:0] res;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

`ifdef SP1_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);
  logic [7:0] cnt_q, cnt_d;

  assign tmo_fire = (state_q == S_OWN) && !done && (cnt_q == TMO_LAST);

  // Counts OWN cycles without done; any release (and therefore any grant) clears it.
  always_comb begin
    cnt_d = 8'd0;
    if (state_q == S_OWN && !release_w) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 8'd0;
    else     cnt_q <= cnt_d;
  end
`else
  assign tmo_fire = 1'b0;
`endif

  assign release_w  = (state_q == S_OWN) && (done || tmo_fire);
  assign rel_ptr    = gnt_id_q + 2'd1;
  // The releasing owner is masked so it can never win a back-to-back re-grant.
  assign masked_req = req & ~gnt_q;
  assign sel_idle   = pick(req, ptr_q);
  assign sel_own    = pick(masked_req, rel_ptr);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      gnt_q    <= 4'b0000;
      gnt_id_q <= 2'd0;
      busy_q   <= 1'b0;
      tmo_q    <= 1'b0;
      ptr_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      busy_q   <= busy_d;
      tmo_q    <= tmo_d;
      ptr_q    <= ptr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req != 4'b0000) state_d = S_OWN;
      S_OWN:   if (release_w && !sel_own[2]) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    busy_d   = busy_q;
    tmo_d    = 1'b0;
    ptr_d    = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (sel_idle[2]) begin
          gnt_d    = 4'b0001 << sel_idle[1:0];
          gnt_id_d = sel_idle[1:0];
          busy_d   = 1'b1;
        end
      end
      S_OWN: begin
        if (release_w) begin
          ptr_d = rel_ptr;
          tmo_d = tmo_fire;
          if (sel_own[2]) begin
            gnt_d    = 4'b0001 << sel_own[1:0];
            gnt_id_d = sel_own[1:0];
            busy_d   = 1'b1;
          end else begin
            gnt_d    = 4'b0000;
            gnt_id_d = 2'd0;
            busy_d   = 1'b0;
          end
        end
      end
      default: begin
        gnt_d    = 4'b0000;
        gnt_id_d = 2'd0;
        busy_d   = 1'b0;
      end
    endcase
  end

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;
  assign busy   = busy_q;
  assign tmo    = tmo_q;

endmodule

// File: tb/tb_sp1_arb4.sv
// Directed and random bench for sp1_arb4; the watchdog section runs only when
// SP1_ARB_TIMEOUT_EN is defined, otherwise grants are checked to be held indefinitely.
module tb_sp1_arb4;

  localparam int unsigned TMO_TB = 4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       tmo;

  int n_checks;
  int n_pass;

  sp1_arb4 #(.TMO(TMO_TB)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .done   (done),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy),
    .tmo    (tmo)
  );

  // Clock and run-time bound
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] id,
                            input logic b, input logic t);
    check({tag, ".gnt"}, 32'(gnt), 32'(g));
    check({tag, ".gnt_id"}, 32'(gnt_id), 32'(id));
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".tmo"}, 32'(tmo), 32'(t));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [1:0] id_of(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  int unsigned rr_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    tick();
    tick();
    expect_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Reset dominates active requests
    req = 4'b1111;
    tick();
    expect_out("reset_req", 4'b0000, 2'd0, 1'b0, 1'b0);

    rst = 1'b0;
    req = 4'b0000;
    tick();
    expect_out("idle_noreq", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single requester grant and release
    req = 4'b0100;
    tick();
    expect_out("grant2", 4'b0100, 2'd2, 1'b1, 1'b0);
    req  = 4'b0000;
    done = 1'b1;
    tick();
    expect_out("release2", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    expect_out("idle_done_ignored", 4'b0000, 2'd0, 1'b0, 1'b0);
    done = 1'b0;

    // Round robin with all requesting, done on every third cycle
    do_reset();
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      expect_out($sformatf("rr%0d", k), 4'b0001 << rr_order[k], 2'(rr_order[k]), 1'b1, 1'b0);
      if (k < 4) begin
        tick();
        check($sformatf("rr%0d_hold1", k), 32'(gnt), 32'(4'b0001 << rr_order[k]));
        tick();
        check($sformatf("rr%0d_hold2", k), 32'(busy), 32'd1);
        done = 1'b1;
        tick();
        done = 1'b0;
      end
    end

    // Owner 0 releases to 3, then owner 3 releases with 0 pending: pointer wraps
    req  = 4'b1000;
    done = 1'b1;
    tick();
    expect_out("to3", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b1001;
    tick();
    expect_out("wrap0", 4'b0001, 2'd0, 1'b1, 1'b0);
    done = 1'b0;

    // Owner drops req without done: grant held, then reset drops it
    req = 4'b0000;
    tick();
    expect_out("hold_noreq1", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick();
    expect_out("hold_noreq2", 4'b0001, 2'd0, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    expect_out("rst_mid_own", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    req = 4'b1010;
    tick();
    expect_out("post_rst_grant", 4'b0010, 2'd1, 1'b1, 1'b0);

    // Sole requester re-granted only after an IDLE cycle
    req  = 4'b0010;
    done = 1'b1;
    tick();
    expect_out("no_b2b_self", 4'b0000, 2'd0, 1'b0, 1'b0);
    done = 1'b0;
    tick();
    expect_out("regrant_after_idle", 4'b0010, 2'd1, 1'b1, 1'b0);

    // Back-to-back from owner 1 with only 0 pending
    req  = 4'b0011;
    done = 1'b1;
    tick();
    expect_out("b2b_to0", 4'b0001, 2'd0, 1'b1, 1'b0);
    done = 1'b0;

`ifdef SP1_ARB_TIMEOUT_EN
    do_reset();
    req = 4'b0011;
    tick();
    expect_out("tmo_grant0", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_out($sformatf("tmo_wait%0d", k), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    tick();
    expect_out("tmo_fire", 4'b0010, 2'd1, 1'b1, 1'b1);
    tick();
    expect_out("tmo_pulse_end", 4'b0010, 2'd1, 1'b1, 1'b0);
    tick();
    tick();
    done = 1'b1;
    tick();
    expect_out("tmo_vs_done", 4'b0001, 2'd0, 1'b1, 1'b0);
    done = 1'b0;
`else
    do_reset();
    req = 4'b0011;
    tick();
    expect_out("hold_grant0", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      tick();
      expect_out($sformatf("hold_long%0d", k), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
`endif

    // Random stimulus with structural checks on every cycle
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      req  = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 3) == 0);
      rst  = ($urandom_range(0, 63) == 0);
      tick();
      check("rand_onehot0", 32'($onehot0(gnt)), 32'd1);
      check("rand_gnt_id", 32'(gnt_id), 32'(id_of(gnt)));
      check("rand_busy", 32'(busy), 32'(gnt != 4'b0000));
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sp1_arb4.md
SP1_ARB4 -- requirements
Module: sp1_arb4

Interface
REQ-001 SHALL have parameter TMO, default 255, meaning timeout limit in cycles (1..255); it is used only with SP1_ARB_TIMEOUT_EN.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port req, input, 4 bits: level request per requester, bit n = requester n.
REQ-005 SHALL have port done, input, 1 bit: the current owner's transaction completes this cycle.
REQ-006 SHALL have port gnt, output, 4 bits, registered: one-hot grant, directly usable as the one-hot select of a 4-to-1 decoded mux.
REQ-007 SHALL have port gnt_id, output, 2 bits, registered: binary index of the granted requester.
REQ-008 SHALL have port busy, output, 1 bit, registered: high while a grant is held.
REQ-009 SHALL have port tmo, output, 1 bit, registered: one-cycle pulse on forced release.

Function
REQ-010 SHALL implement a two-state FSM: IDLE (gnt=0, busy=0) and OWN (gnt one-hot, busy=1).
REQ-011 SHALL keep gnt either 4'b0000 or exactly one bit set in every cycle; gnt_id SHALL equal the index of the set bit, or 0 when gnt=0.
REQ-012 SHALL, in IDLE with req!=0, select the first requester at or after pointer ptr, in ascending modulo-4 order; gnt, gnt_id, busy SHALL be registered the next cycle and the FSM SHALL enter OWN.
REQ-013 SHALL, in IDLE with req=0, remain in IDLE with outputs unchanged.
REQ-014 SHALL hold gnt unchanged in OWN until done=1, even if the owner's req bit deasserts.
REQ-015 SHALL set ptr to (gnt_id+1) mod 4, a 2-bit wrap from 3 to 0, on every release.
REQ-016 SHALL, on done=1 in OWN with no other requester pending (req with the owner's bit masked = 0), drive gnt=0 and busy=0 the next cycle and return to IDLE.
REQ-017 SHALL, on done=1 in OWN with another requester pending, grant the next requester by the round-robin rule using the updated ptr in the very next cycle, without an idle cycle; busy SHALL stay 1.
REQ-018 SHALL exclude the releasing owner from a back-to-back re-grant; it becomes eligible again only after some other grant or after IDLE.
REQ-019 SHALL ignore done while in IDLE.
REQ-020 SHALL grant each of 4 continuously asserted requesters exactly once per 4 consecutive grants (starvation-free).

Reset
REQ-021 SHALL, while rst=1, force FSM=IDLE, gnt=4'b0000, gnt_id=2'd0, busy=0, tmo=0, ptr=0, timeout counter=0, regardless of other inputs.
REQ-022 SHALL, on rst asserted mid-OWN, drop the grant the next edge with no tmo pulse; the first grant after reset SHALL use ptr=0.

Configuration
REQ-023 SHALL compile the timeout watchdog only when macro SP1_ARB_TIMEOUT_EN is defined.
REQ-024 SHALL, with SP1_ARB_TIMEOUT_EN defined, count cycles spent in OWN with done=0 using an 8-bit counter cleared on every grant; when the count reaches TMO the block SHALL release exactly as for done=1 (REQ-015..REQ-018) and pulse tmo=1 for one cycle, aligned with the cycle the new gnt value appears.
REQ-025 SHALL, with SP1_ARB_TIMEOUT_EN defined and done=1 in the same cycle the count reaches TMO, treat the event as a normal release with tmo=0.
REQ-026 SHALL, without SP1_ARB_TIMEOUT_EN, tie tmo to constant 0, hold grants indefinitely, and include no counter logic; the port list SHALL be identical in both builds.

Verification
REQ-027 SHALL cover reset then req=4'b0100 -> cycle+1: gnt=4'b0100, gnt_id=2, busy=1; done pulse -> cycle+1: gnt=0, busy=0.
REQ-028 SHALL cover req=4'b1111 held with done pulsed every 3rd cycle -> grant order 0,1,2,3,0 back-to-back with busy constantly 1.
REQ-029 SHALL cover owner 3 with req=4'b1001 pending and done=1 -> ptr wraps to 0 and the next-cycle gnt=4'b0001.
REQ-030 SHALL cover the owner dropping req mid-OWN with no done -> gnt held; rst pulse -> next cycle gnt=0, tmo=0, and the next grant with req=4'b1010 goes to 1.
REQ-031 SHALL cover, with SP1_ARB_TIMEOUT_EN and TMO=4, req=4'b0011 and done held 0 -> requester 0 is released after 4 OWN cycles, tmo=1 for one cycle, gnt=4'b0010 in the same cycle.
REQ-032 SHALL cover a random req/done/rst stimulus for at least 10k cycles with assertions -> gnt is one-hot or zero, and gnt_id is consistent with gnt.
